adder_bist: RTL

Synthesizable built-in self-test initiator for the registered 5-bit carry-in adder. It drives `a`, `b`, `c_in` with one directed vector followed by an LFSR-generated random sequence. It checks the adder's registered `s`/`c_out` against an internal golden model delayed by the adder latency, then reports an error count, the first failing vector and pass/fail. It sits beside the adder on the same clock and replaces the simulation-only stimulus loop in hardware bring-up.

---
 rtl/adder_bist_pkg.sv | 23 ++
 rtl/adder_bist_lfsr.sv | 31 +++
 rtl/adder_bist.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/adder_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_bist_pkg
// Description : Shared types and constants for the adder BIST initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DIRECTED = 3'd1,
        S_RANDOM   = 3'd2,
        S_DRAIN    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam int          ERR_W        = 8;
    localparam int          IDX_W        = 10;

endpackage
`default_nettype wire

// File: rtl/adder_bist_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : adder_bist_lfsr
// Description : 16-bit right-shifting Galois LFSR with synchronous load.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_bist_lfsr
    import adder_bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] q
);

    logic [15:0] r_q;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_q <= seed;
        end else if (advance) begin
            r_q <= r_q[0] ? ((r_q >> 1) ^ LFSR_MASK) : (r_q >> 1);
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/adder_bist.sv
`default_nettype none
// ============================================================================
// Module      : adder_bist
// Description : Self-test initiator for the registered carry-in adder: one
//               directed vector, an LFSR sequence, delayed golden compare.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_bist
    import adder_bist_pkg::*;
#(
    parameter int          WIDTH       = 5,
    parameter int          NUM_VECTORS = 20,
    parameter int          LATENCY     = 1,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   a,
    output logic [WIDTH-1:0]   b,
    output logic               c_in,
    input  logic [WIDTH-1:0]   s,
    input  logic               c_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_cnt,
    output logic [IDX_W-1:0]   fail_idx,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b,
    output logic               fail_cin
);

    localparam logic [15:0] c_seed  = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;
    localparam int          c_ent_w = 1 + IDX_W + 3 * WIDTH + 2;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_c_in;
    logic               r_drv_valid;
    logic [IDX_W-1:0]   r_drv_idx;
    logic [IDX_W-1:0]   r_idx;
    logic [2:0]         r_drain;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [ERR_W-1:0]   r_err_cnt;
    logic               r_first_fail;
    logic [IDX_W-1:0]   r_fail_idx;
    logic [WIDTH-1:0]   r_fail_a;
    logic [WIDTH-1:0]   r_fail_b;
    logic               r_fail_cin;
    logic [c_ent_w-1:0] r_pipe [LATENCY];

    logic               w_start_acc;
    logic [15:0]        w_q;
    logic               w_unused_q;
    logic [WIDTH:0]     w_exp;
    logic [c_ent_w-1:0] w_ent;
    logic [c_ent_w-1:0] w_tail;
    logic               w_t_valid;
    logic [IDX_W-1:0]   w_t_idx;
    logic [WIDTH-1:0]   w_t_a;
    logic [WIDTH-1:0]   w_t_b;
    logic               w_t_cin;
    logic [WIDTH:0]     w_t_exp;
    logic               w_mismatch;

    assign w_start_acc = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    adder_bist_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (w_start_acc),
        .seed    (c_seed),
        .advance (r_state == S_RANDOM),
        .q       (w_q)
    );

    assign w_unused_q = ^w_q[15:2*WIDTH+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_c_in      <= 1'b0;
            r_drv_valid <= 1'b0;
            r_drv_idx   <= '0;
            r_idx       <= '0;
            r_drain     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_a         <= '0;
                    r_b         <= '0;
                    r_c_in      <= 1'b0;
                    r_drv_valid <= 1'b0;
                    if (start) begin
                        r_state <= S_DIRECTED;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                    end else if (r_state == S_DONE) begin
                        // Flags follow the DONE state by one edge so the last compare is already counted.
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_pass <= (r_err_cnt == '0);
                    end
                end
                S_DIRECTED: begin
                    r_a         <= WIDTH'(1);
                    r_b         <= WIDTH'(1);
                    r_c_in      <= 1'b1;
                    r_drv_valid <= 1'b1;
                    r_drv_idx   <= '0;
                    r_idx       <= IDX_W'(1);
                    r_busy      <= 1'b1;
                    r_state     <= S_RANDOM;
                end
                S_RANDOM: begin
                    r_a         <= w_q[WIDTH-1:0];
                    r_b         <= w_q[2*WIDTH-1:WIDTH];
                    r_c_in      <= w_q[2*WIDTH];
                    r_drv_valid <= 1'b1;
                    r_drv_idx   <= r_idx;
                    r_idx       <= r_idx + IDX_W'(1);
                    if (r_idx == IDX_W'(NUM_VECTORS)) begin
                        r_state <= S_DRAIN;
                        r_drain <= '0;
                    end
                end
                S_DRAIN: begin
                    r_a         <= '0;
                    r_b         <= '0;
                    r_c_in      <= 1'b0;
                    r_drv_valid <= 1'b0;
                    if (r_drain == 3'(LATENCY)) begin
                        r_state <= S_DONE;
                    end else begin
                        r_drain <= r_drain + 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Expected value is taken from the operands as they leave the flops.
    assign w_exp = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_c_in};
    assign w_ent = {r_drv_valid, r_drv_idx, r_a, r_b, r_c_in, w_exp};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= w_ent;
            for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign w_tail     = r_pipe[LATENCY-1];
    assign w_t_valid  = w_tail[c_ent_w-1];
    assign w_t_idx    = w_tail[c_ent_w-2 -: IDX_W];
    assign w_t_a      = w_tail[3*WIDTH+1 -: WIDTH];
    assign w_t_b      = w_tail[2*WIDTH+1 -: WIDTH];
    assign w_t_cin    = w_tail[WIDTH+1];
    assign w_t_exp    = w_tail[WIDTH:0];
    assign w_mismatch = w_t_valid && ({c_out, s} != w_t_exp);

    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_err_cnt    <= '0;
            r_first_fail <= 1'b0;
            r_fail_idx   <= '0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
            r_fail_cin   <= 1'b0;
        end else if (w_mismatch) begin
            if (r_err_cnt != {ERR_W{1'b1}}) r_err_cnt <= r_err_cnt + ERR_W'(1);
            if (!r_first_fail) begin
                r_first_fail <= 1'b1;
                r_fail_idx   <= w_t_idx;
                r_fail_a     <= w_t_a;
                r_fail_b     <= w_t_b;
                r_fail_cin   <= w_t_cin;
            end
        end
    end

    assign a        = r_a;
    assign b        = r_b;
    assign c_in     = r_c_in;
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign err_cnt  = r_err_cnt;
    assign fail_idx = r_fail_idx;
    assign fail_a   = r_fail_a;
    assign fail_b   = r_fail_b;
    assign fail_cin = r_fail_cin;

endmodule
`default_nettype wire
